// File: rtl/data_mem_pkg.sv
// Shared constants for the M-stage data port responder: MMIO map, status bits
// and the default MMIO region selector.
package data_mem_pkg;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFFFF;

    localparam logic [15:0] LED_OFF    = 16'h0000;
    localparam logic [15:0] CYCLE_OFF  = 16'h0004;
    localparam logic [15:0] TIMER_OFF  = 16'h0008;
    localparam logic [15:0] STATUS_OFF = 16'h000C;

    localparam int ST_TIMER    = 0;
    localparam int ST_MISALIGN = 1;

endpackage

// File: rtl/dmem_ram.sv
// Word RAM backing the data port: asynchronous read, synchronous write.
// Contents are deliberately not reset.
module dmem_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    // Combinational read of the addressed word (pre-edge contents)
    always_comb begin
        rdata_o = mem_q[addr_i];
    end

    // Write commit at the rising edge
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU M-stage data port: word RAM plus an MMIO block with
// LED, free-running cycle counter, countdown timer and sticky status flags.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [15:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic [15:0] led,
    output logic        timer_irq,
    output logic        err
);

    logic [15:0] led_q,    led_d;
    logic [31:0] cycle_q,  cycle_d;
    logic [31:0] timer_q,  timer_d;
    logic [1:0]  status_q, status_d;

    logic                  mmio_s;
    logic                  misaligned_s;
    logic [15:0]           off_s;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  ram_we_s;
    logic                  mmio_we_s;
    logic                  timer_load_s;
    logic                  expire_s;
    logic [1:0]            clr_s;
    logic [1:0]            set_s;
    logic [31:0]           ram_rdata_s;

    assign mmio_s       = (ALUResultM[31:16] == MMIO_BASE);
    assign misaligned_s = (ALUResultM[1:0] != 2'b00);
    assign off_s        = ALUResultM[15:0];
    assign idx_s        = ALUResultM[ADDR_WIDTH+1:2];

    // Writes are dropped entirely while reset is asserted
    assign ram_we_s  = rst & MemWriteM & ~mmio_s & ~misaligned_s;
    assign mmio_we_s = MemWriteM & mmio_s & ~misaligned_s;

    dmem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (idx_s),
        .wdata_i (WriteDataM),
        .rdata_o (ram_rdata_s)
    );

    // Read mux: zero for idle, misaligned or unmapped accesses
    always_comb begin
        ReadDataM = 32'd0;
        if (MemReadM && !misaligned_s) begin
            if (mmio_s) begin
                case (off_s)
                    LED_OFF:    ReadDataM = {16'd0, led_q};
                    CYCLE_OFF:  ReadDataM = cycle_q;
                    TIMER_OFF:  ReadDataM = timer_q;
                    STATUS_OFF: ReadDataM = {30'd0, status_q};
                    default:    ReadDataM = 32'd0;
                endcase
            end else begin
                ReadDataM = ram_rdata_s;
            end
        end else begin
            ReadDataM = 32'd0;
        end
    end

    // MMIO next-state: a load beats the 1->0 step, a set beats a clear
    always_comb begin
        led_d        = led_q;
        cycle_d      = cycle_q + 32'd1;
        timer_load_s = mmio_we_s && (off_s == TIMER_OFF);
        clr_s        = 2'b00;
        set_s        = 2'b00;
        if (mmio_we_s && (off_s == LED_OFF)) begin
            led_d = WriteDataM[15:0];
        end else begin
            led_d = led_q;
        end
        if (timer_load_s) begin
            timer_d = WriteDataM;
        end else if (timer_q != 32'd0) begin
            timer_d = timer_q - 32'd1;
        end else begin
            timer_d = timer_q;
        end
        expire_s = (timer_q == 32'd1) && !timer_load_s;
        if (mmio_we_s && (off_s == STATUS_OFF)) begin
            clr_s = WriteDataM[1:0];
        end else begin
            clr_s = 2'b00;
        end
        set_s[ST_TIMER]    = expire_s;
        set_s[ST_MISALIGN] = (MemReadM | MemWriteM) & misaligned_s;
        status_d           = (status_q & ~clr_s) | set_s;
    end

    // MMIO register state; reset overrides every other update
    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q    <= 16'd0;
            cycle_q  <= 32'd0;
            timer_q  <= 32'd0;
            status_q <= 2'b00;
        end else begin
            led_q    <= led_d;
            cycle_q  <= cycle_d;
            timer_q  <= timer_d;
            status_q <= status_d;
        end
    end

    assign led       = led_q;
    assign timer_irq = status_q[ST_TIMER];
    assign err       = status_q[ST_MISALIGN];

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed stimulus pushes expected
// values; a monitor on the falling edge pops and compares them.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [15:0] led;
    logic        timer_irq;
    logic        err;

    int tests_run;
    int tests_failed;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    data_mem_responder #(
        .ADDR_WIDTH (10),
        .MMIO_BASE  (16'hFFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .led        (led),
        .timer_irq  (timer_irq),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation mid-cycle
    always @(negedge clk) begin
        logic [31:0] act;
        exp_t        e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       act = ReadDataM;
                1:       act = {16'd0, led};
                2:       act = {31'd0, timer_irq};
                default: act = {31'd0, err};
            endcase
            tests_run = tests_run + 1;
            if (act !== e.exp) begin
                tests_failed = tests_failed + 1;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = a;
        WriteDataM = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic expect_val(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        idle();
        tick();
        tick();
        // First cycle after reset release: counter reads 0
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'hFFFF0004, 32'd0);
        expect_val("rst_cycle0", 0, 32'd0);
        expect_val("rst_led", 1, 32'd0);
        expect_val("rst_irq", 2, 32'd0);
        expect_val("rst_err", 3, 32'd0);
        tick();
        idle();
        for (int i = 0; i < 9; i++) tick();
        drive(1'b1, 1'b0, 32'hFFFF0004, 32'd0);
        expect_val("cycle_10", 0, 32'd10);
        tick();

        drive(1'b0, 1'b1, 32'hFFFF0000, 32'hABCD1234);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF0000, 32'd0);
        expect_val("led_out", 1, 32'h00001234);
        expect_val("led_read", 0, 32'h00001234);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF0010, 32'd0);
        expect_val("unmapped_rd", 0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'hFFFF0000, 32'd0);
        expect_val("no_read_zero", 0, 32'd0);
        tick();

        drive(1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF);
        tick();
        drive(1'b1, 1'b0, 32'h00000010, 32'd0);
        expect_val("ram_rd", 0, 32'hDEADBEEF);
        tick();
        drive(1'b1, 1'b0, 32'h00001010, 32'd0);
        expect_val("ram_alias", 0, 32'hDEADBEEF);
        tick();

        drive(1'b0, 1'b1, 32'h00000020, 32'h11111111);
        tick();
        drive(1'b1, 1'b1, 32'h00000020, 32'h22222222);
        expect_val("rw_old", 0, 32'h11111111);
        tick();
        drive(1'b1, 1'b0, 32'h00000020, 32'd0);
        expect_val("rw_new", 0, 32'h22222222);
        tick();

        drive(1'b0, 1'b1, 32'h00000022, 32'h12345678);
        expect_val("mis_err_before", 3, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h00000020, 32'd0);
        expect_val("mis_ram_kept", 0, 32'h22222222);
        expect_val("mis_err_set", 3, 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'h00000022, 32'd0);
        expect_val("mis_rd_zero", 0, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'hFFFF000C, 32'h00000002);
        expect_val("err_before_clr", 3, 32'd1);
        tick();
        idle();
        expect_val("err_cleared", 3, 32'd0);
        tick();

        // Countdown from 3 and expiry flag
        drive(1'b0, 1'b1, 32'hFFFF0008, 32'd3);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF0008, 32'd0);
        expect_val("timer_3", 0, 32'd3);
        tick();
        expect_val("timer_2", 0, 32'd2);
        tick();
        expect_val("timer_1", 0, 32'd1);
        expect_val("irq_pre", 2, 32'd0);
        tick();
        expect_val("timer_0", 0, 32'd0);
        expect_val("irq_set", 2, 32'd1);
        tick();
        drive(1'b0, 1'b1, 32'hFFFF000C, 32'h00000001);
        tick();
        idle();
        expect_val("irq_cleared", 2, 32'd0);

        // Reload on the 1->0 cycle wins
        drive(1'b0, 1'b1, 32'hFFFF0008, 32'd2);
        tick();
        idle();
        tick();
        drive(1'b0, 1'b1, 32'hFFFF0008, 32'd5);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF0008, 32'd0);
        expect_val("reload_5", 0, 32'd5);
        expect_val("reload_no_irq", 2, 32'd0);
        tick();
        expect_val("reload_4", 0, 32'd4);
        tick();

        // Clear in the same cycle as expiry: set wins
        drive(1'b0, 1'b1, 32'hFFFF0008, 32'd2);
        tick();
        idle();
        tick();
        drive(1'b0, 1'b1, 32'hFFFF000C, 32'h00000001);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF0008, 32'd0);
        expect_val("setwins_timer", 0, 32'd0);
        expect_val("setwins_irq", 2, 32'd1);
        tick();

        // Reset mid-operation
        drive(1'b0, 1'b1, 32'hFFFF0008, 32'd100);
        tick();
        drive(1'b0, 1'b1, 32'hFFFF0000, 32'h0000FFFF);
        tick();
        drive(1'b1, 1'b0, 32'h00000001, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF000C, 32'd0);
        expect_val("pre_rst_status", 0, 32'd3);
        expect_val("pre_rst_led", 1, 32'h0000FFFF);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h00000010, 32'h00000055);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'hFFFF0004, 32'd0);
        expect_val("post_rst_cycle", 0, 32'd0);
        expect_val("post_rst_led", 1, 32'd0);
        expect_val("post_rst_irq", 2, 32'd0);
        expect_val("post_rst_err", 3, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'hFFFF0008, 32'd0);
        expect_val("post_rst_timer", 0, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h00000010, 32'd0);
        expect_val("ram_survives_rst", 0, 32'hDEADBEEF);
        expect_val("post_rst_no_expiry", 2, 32'd0);
        tick();
        idle();

        @(negedge clk);
        #1;
        tests_run = tests_run + 1;
        if (sb_q.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
